// File: rtl/parking_pkg.sv
// ---------------------------------------------------------------------------
// parking_pkg
// Shared definitions for the parking-lot barrier lane:
//   - barrier FSM state encodings (REPOSO .. FALLA)
//   - lane direction constants (DIR_ENTRADA / DIR_SALIDA)
//   - free-space count width, shared with the space counter
//   - registered-output bundle and its decode from (state, grant)
// ---------------------------------------------------------------------------
package parking_pkg;

    // Width of the free-space count produced by the space counter.
    localparam int ESPACIO_W = 7;

    // Barrier FSM states.
    typedef logic [2:0] estado_t;
    localparam estado_t REPOSO   = 3'd0;
    localparam estado_t ABRIENDO = 3'd1;
    localparam estado_t ABIERTA  = 3'd2;
    localparam estado_t ESPERA   = 3'd3;
    localparam estado_t CERRANDO = 3'd4;
    localparam estado_t FALLA    = 3'd5;

    // Lane direction; also used as the index into per-direction vectors.
    typedef logic dir_t;
    localparam dir_t DIR_ENTRADA = 1'b0;
    localparam dir_t DIR_SALIDA  = 1'b1;

    // Outputs that are a pure function of (state, grant).
    typedef struct packed {
        logic motor_abrir;
        logic motor_cerrar;
        logic verde_entrada;
        logic verde_salida;
        logic falla;
    } salidas_t;

    // Decode the lane outputs for a given state and granted direction.
    // Opening and closing are separate states, so the two motor drives
    // can never be active together.
    function automatic salidas_t decodificar(input estado_t st, input dir_t g);
        salidas_t s;
        s = '0;
        case (st)
            ABRIENDO: s.motor_abrir  = 1'b1;
            ABIERTA,
            ESPERA: begin
                if (g == DIR_ENTRADA) s.verde_entrada = 1'b1;
                else                  s.verde_salida  = 1'b1;
            end
            CERRANDO: s.motor_cerrar = 1'b1;
            FALLA:    s.falla        = 1'b1;
            default:  s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/control_barrera_temporizador.sv
// ---------------------------------------------------------------------------
// temporizador
// Free-running up-counter with synchronous clear and a terminal-compare flag.
//   clk     : system clock
//   reset   : asynchronous, active-low reset
//   clr     : synchronous clear (count returns to 0 on the next edge)
//   limite  : terminal value to compare against
//   fin     : high while the current count equals limite
// ---------------------------------------------------------------------------
module temporizador #(
    parameter int TIMER_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic [TIMER_W-1:0] limite,
    output logic               fin
);

    logic [TIMER_W-1:0] cuenta_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cuenta_reg <= '0;
        end else if (clr) begin
            cuenta_reg <= '0;
        end else begin
            cuenta_reg <= cuenta_reg + 1'b1;
        end
    end

    assign fin = (cuenta_reg == limite);

endmodule

// File: rtl/control_barrera.sv
// ---------------------------------------------------------------------------
// control_barrera
// Controller for the single shared barrier lane (entry and exit share it).
// Latches entry/exit requests, arbitrates between them (alternating when both
// are eligible), blocks entry while the lot is full and sequences the barrier
// motor through open / hold / close using the limit switches and a timer.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   req_entrada/salida  1-cycle debounced lane requests
//   espacio             free spaces from the space counter
//   entrada/salida      1-cycle "car completed" pulses from the detector
//   fin_abierta/cerrada synchronized open/closed limit switches
//   obstaculo           object under the barrier (level)
//   motor_abrir/cerrar  motor drives
//   verde_entrada/salida lane green lights
//   lleno               entry request pending while espacio == 0
//   falla               sticky motor / limit-switch fault
//
// Build option: ANTIPINZA_EN -- when defined, an obstacle during closing
// reopens the barrier for the same grant; otherwise obstaculo is unused.
// ---------------------------------------------------------------------------
module control_barrera
    import parking_pkg::*;
#(
    parameter int                 TIMER_W     = 16,
    parameter logic [TIMER_W-1:0] T_MOTOR_MAX = 16'd5000,
    parameter logic [TIMER_W-1:0] T_PASO      = 16'd50000,
    parameter logic [TIMER_W-1:0] T_CIERRE    = 16'd2000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_entrada,
    input  logic                 req_salida,
    input  logic [ESPACIO_W-1:0] espacio,
    input  logic                 entrada,
    input  logic                 salida,
    input  logic                 fin_abierta,
    input  logic                 fin_cerrada,
    input  logic                 obstaculo,
    output logic                 motor_abrir,
    output logic                 motor_cerrar,
    output logic                 verde_entrada,
    output logic                 verde_salida,
    output logic                 lleno,
    output logic                 falla
);

    // Timers fire on the last cycle of the allowed window.
    localparam logic [TIMER_W-1:0] LIM_MOTOR  = T_MOTOR_MAX - 1'b1;
    localparam logic [TIMER_W-1:0] LIM_PASO   = T_PASO      - 1'b1;
    localparam logic [TIMER_W-1:0] LIM_CIERRE = T_CIERRE    - 1'b1;

    estado_t    state_reg,  state_next;
    dir_t       grant_reg,  grant_next;
    dir_t       ultimo_reg, ultimo_next;
    logic [1:0] pend_reg,   pend_next;
    salidas_t   salidas_reg;
    logic       lleno_reg;

    logic [1:0] req_vec;
    logic [1:0] pend_eff;
    logic       elegible_ent;
    logic       elegible_sal;
    logic       toma;
    logic       paso;

    logic [TIMER_W-1:0] limite;
    logic               timer_fin;
    logic               timer_clr;

    // Per-direction request vector, indexed by DIR_ENTRADA / DIR_SALIDA.
    assign req_vec = {req_salida, req_entrada};

    // A request arriving this cycle is treated as already pending so that an
    // idle barrier reacts on the very next edge; it is still latched if it
    // cannot be granted immediately.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_pend
            assign pend_eff[gi]  = pend_reg[gi] | req_vec[gi];
            // Cleared when its grant is taken; a request for the direction
            // currently in service (not idle) re-arms it for the next round.
            assign pend_next[gi] = (toma && (grant_next == dir_t'(gi))) ? 1'b0
                                                                        : pend_eff[gi];
        end
    endgenerate

    assign elegible_ent = pend_eff[DIR_ENTRADA] && (espacio != '0);
    assign elegible_sal = pend_eff[DIR_SALIDA];

    // Only the pass pulse of the granted direction closes the open phase.
    assign paso = (grant_reg == DIR_ENTRADA) ? entrada : salida;

    // Timer window for the current state.
    always_comb begin
        limite = LIM_MOTOR;
        case (state_reg)
            ABIERTA: limite = LIM_PASO;
            ESPERA:  limite = LIM_CIERRE;
            default: limite = LIM_MOTOR;
        endcase
    end

    // Next-state, arbitration and grant logic.
    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        ultimo_next = ultimo_reg;
        toma        = 1'b0;

        case (state_reg)
            REPOSO: begin
                if (elegible_ent || elegible_sal) begin
                    toma        = 1'b1;
                    state_next  = ABRIENDO;
                    if (elegible_ent && elegible_sal) begin
                        // Both waiting: serve the one not served last.
                        grant_next = ~ultimo_reg;
                    end else if (elegible_ent) begin
                        grant_next = DIR_ENTRADA;
                    end else begin
                        grant_next = DIR_SALIDA;
                    end
                    ultimo_next = grant_next;
                end
            end
            ABRIENDO: begin
                if (fin_abierta)    state_next = ABIERTA;
                else if (timer_fin) state_next = FALLA;
            end
            ABIERTA: begin
                if (paso)           state_next = ESPERA;
                else if (timer_fin) state_next = CERRANDO;
            end
            ESPERA: begin
                if (timer_fin)      state_next = CERRANDO;
            end
            CERRANDO: begin
                if (fin_cerrada)    state_next = REPOSO;
`ifdef ANTIPINZA_EN
                // Reopen for the same grant; no new arbitration.
                else if (obstaculo) state_next = ABRIENDO;
`endif
                else if (timer_fin) state_next = FALLA;
            end
            FALLA: begin
                state_next = FALLA;
            end
            default: begin
                state_next = REPOSO;
            end
        endcase

        // Both limit switches at once is physically impossible: wiring or
        // sensor fault. Overrides everything, including a grant in REPOSO.
        if (fin_abierta && fin_cerrada) begin
            state_next  = FALLA;
            grant_next  = grant_reg;
            ultimo_next = ultimo_reg;
            toma        = 1'b0;
        end
    end

`ifndef ANTIPINZA_EN
    logic unused_obstaculo;
    assign unused_obstaculo = obstaculo;
`endif

    // Every state entry restarts the timer.
    assign timer_clr = (state_next != state_reg);

    temporizador #(
        .TIMER_W (TIMER_W)
    ) u_temporizador (
        .clk    (clk),
        .reset  (reset),
        .clr    (timer_clr),
        .limite (limite),
        .fin    (timer_fin)
    );

    // Outputs are decoded from the next state so they line up with state_reg.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= REPOSO;
            grant_reg   <= DIR_ENTRADA;
            ultimo_reg  <= DIR_SALIDA;
            pend_reg    <= '0;
            salidas_reg <= '0;
            lleno_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            ultimo_reg  <= ultimo_next;
            pend_reg    <= pend_next;
            salidas_reg <= decodificar(state_next, grant_next);
            lleno_reg   <= pend_next[DIR_ENTRADA] && (espacio == '0);
        end
    end

    assign motor_abrir   = salidas_reg.motor_abrir;
    assign motor_cerrar  = salidas_reg.motor_cerrar;
    assign verde_entrada = salidas_reg.verde_entrada;
    assign verde_salida  = salidas_reg.verde_salida;
    assign falla         = salidas_reg.falla;
    assign lleno         = lleno_reg;

endmodule

// File: tb/tb_control_barrera.sv
// ---------------------------------------------------------------------------
// tb_control_barrera
// Directed bench for the barrier controller with short timers
// (T_MOTOR_MAX=16, T_PASO=32, T_CIERRE=4). Inputs change 1 time unit after
// the rising edge; outputs are read at the same point, so a value read after
// tick() is the one registered at that edge.
// ---------------------------------------------------------------------------
module tb_control_barrera;

    localparam int MOTOR  = 16;
    localparam int PASO   = 32;
    localparam int CIERRE = 4;

    logic       clk;
    logic       reset;
    logic       req_entrada;
    logic       req_salida;
    logic [6:0] espacio;
    logic       entrada;
    logic       salida;
    logic       fin_abierta;
    logic       fin_cerrada;
    logic       obstaculo;
    logic       motor_abrir;
    logic       motor_cerrar;
    logic       verde_entrada;
    logic       verde_salida;
    logic       lleno;
    logic       falla;

    int n_cmp;
    int n_bad;

    control_barrera #(
        .TIMER_W     (16),
        .T_MOTOR_MAX (16'd16),
        .T_PASO      (16'd32),
        .T_CIERRE    (16'd4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_entrada   (req_entrada),
        .req_salida    (req_salida),
        .espacio       (espacio),
        .entrada       (entrada),
        .salida        (salida),
        .fin_abierta   (fin_abierta),
        .fin_cerrada   (fin_cerrada),
        .obstaculo     (obstaculo),
        .motor_abrir   (motor_abrir),
        .motor_cerrar  (motor_cerrar),
        .verde_entrada (verde_entrada),
        .verde_salida  (verde_salida),
        .lleno         (lleno),
        .falla         (falla)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [5:0] outs();
        return {motor_abrir, motor_cerrar, verde_entrada, verde_salida, lleno, falla};
    endfunction

    // Asserts reset between clock edges: outputs must drop without a clock.
    task automatic do_reset();
        reset = 1'b0;
        #2;
        chk("rst_async_outs", 32'(outs()), 32'h0);
        req_entrada = 1'b0;
        req_salida  = 1'b0;
        entrada     = 1'b0;
        salida      = 1'b0;
        obstaculo   = 1'b0;
        fin_abierta = 1'b0;
        fin_cerrada = 1'b1;
        espacio     = 7'd10;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    // Drives one full barrier cycle for direction 'sal' (0 entry, 1 exit),
    // starting right after motor_abrir was seen high. Ends on the edge that
    // samples fin_cerrada (barrier back at rest).
    task automatic run_pass(input logic sal);
        fin_cerrada = 1'b0;
        ticks(2);
        fin_abierta = 1'b1;
        tick();
        chk("open_verde_ent", 32'(verde_entrada), 32'(!sal));
        chk("open_verde_sal", 32'(verde_salida), 32'(sal));
        chk("open_motor_off", 32'({motor_abrir, motor_cerrar}), 32'h0);
        // Pass pulse for the other lane must not start the close delay.
        if (sal) entrada = 1'b1; else salida = 1'b1;
        tick();
        entrada = 1'b0;
        salida  = 1'b0;
        if (sal) salida = 1'b1; else entrada = 1'b1;
        tick();
        entrada = 1'b0;
        salida  = 1'b0;
        chk("espera_verde", 32'({verde_entrada, verde_salida}), sal ? 32'h1 : 32'h2);
        ticks(CIERRE - 1);
        chk("espera_no_cierra", 32'(motor_cerrar), 32'h0);
        tick();
        chk("cierra_motor", 32'(motor_cerrar), 32'h1);
        chk("cierra_luces", 32'({verde_entrada, verde_salida}), 32'h0);
        fin_abierta = 1'b0;
        tick();
        fin_cerrada = 1'b1;
        tick();
        chk("cerrada_motor_off", 32'({motor_abrir, motor_cerrar}), 32'h0);
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        reset       = 1'b0;
        req_entrada = 1'b0;
        req_salida  = 1'b0;
        espacio     = 7'd10;
        entrada     = 1'b0;
        salida      = 1'b0;
        fin_abierta = 1'b0;
        fin_cerrada = 1'b1;
        obstaculo   = 1'b0;
        #12;
        chk("reset_outs", 32'(outs()), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("idle_outs", 32'(outs()), 32'h0);

        // Entry with espacio=10.
        req_entrada = 1'b1;
        tick();
        req_entrada = 1'b0;
        chk("ent_abrir", 32'(motor_abrir), 32'h1);
        chk("ent_no_cerrar", 32'(motor_cerrar), 32'h0);
        fin_cerrada = 1'b0;
        ticks(4);
        chk("ent_abrir_hold", 32'(motor_abrir), 32'h1);
        fin_abierta = 1'b1;
        tick();
        chk("ent_verde", 32'({verde_entrada, verde_salida}), 32'h2);
        ticks(4);
        entrada = 1'b1;
        tick();
        entrada = 1'b0;
        ticks(CIERRE - 1);
        chk("ent_cerrar_early", 32'(motor_cerrar), 32'h0);
        tick();
        chk("ent_cerrar", 32'(motor_cerrar), 32'h1);
        fin_abierta = 1'b0;
        tick();
        fin_cerrada = 1'b1;
        tick();
        tick();
        chk("ent_reposo", 32'(outs()), 32'h0);

        // Full lot: entry waits, lleno raised, granted once a space frees.
        do_reset();
        espacio = 7'd0;
        req_entrada = 1'b1;
        tick();
        req_entrada = 1'b0;
        chk("lleno_set", 32'(lleno), 32'h1);
        chk("lleno_motor_idle", 32'({motor_abrir, motor_cerrar}), 32'h0);
        ticks(19);
        chk("lleno_hold", 32'(lleno), 32'h1);
        chk("lleno_idle_hold", 32'(motor_abrir), 32'h0);
        espacio = 7'd1;
        tick();
        chk("lleno_grant", 32'(motor_abrir), 32'h1);
        chk("lleno_clear", 32'(lleno), 32'h0);
        run_pass(1'b0);
        espacio = 7'd10;

        // Simultaneous requests after reset: entry, then exit.
        do_reset();
        req_entrada = 1'b1;
        req_salida  = 1'b1;
        tick();
        req_entrada = 1'b0;
        req_salida  = 1'b0;
        chk("sim1_abrir", 32'(motor_abrir), 32'h1);
        run_pass(1'b0);
        tick();
        chk("sim1_second_grant", 32'(motor_abrir), 32'h1);
        run_pass(1'b1);
        tick();
        chk("sim1_done", 32'(motor_abrir), 32'h0);
        // Lone entry leaves ultimo=ENTRADA, so the next tie goes to exit.
        req_entrada = 1'b1;
        tick();
        req_entrada = 1'b0;
        run_pass(1'b0);
        tick();
        req_entrada = 1'b1;
        req_salida  = 1'b1;
        tick();
        req_entrada = 1'b0;
        req_salida  = 1'b0;
        chk("sim2_abrir", 32'(motor_abrir), 32'h1);
        run_pass(1'b1);
        tick();
        chk("sim2_second_grant", 32'(motor_abrir), 32'h1);
        run_pass(1'b0);
        tick();
        chk("sim2_done", 32'(motor_abrir), 32'h0);

        // No pass: open phase times out and closes.
        do_reset();
        req_salida = 1'b1;
        tick();
        req_salida = 1'b0;
        fin_cerrada = 1'b0;
        tick();
        fin_abierta = 1'b1;
        tick();
        chk("nopass_verde", 32'({verde_entrada, verde_salida}), 32'h1);
        ticks(PASO - 1);
        chk("nopass_still_open", 32'({motor_cerrar, verde_salida}), 32'h1);
        tick();
        chk("nopass_cerrar", 32'({motor_cerrar, verde_salida}), 32'h2);
        fin_abierta = 1'b0;
        tick();
        fin_cerrada = 1'b1;
        ticks(3);
        chk("nopass_idle", 32'(outs()), 32'h0);

        // Motor fault: open limit never reached.
        do_reset();
        req_entrada = 1'b1;
        tick();
        req_entrada = 1'b0;
        fin_cerrada = 1'b0;
        ticks(MOTOR - 1);
        chk("fault_not_yet", 32'({motor_abrir, falla}), 32'h2);
        tick();
        chk("fault_set", 32'(outs()), 32'h1);
        req_salida = 1'b1;
        tick();
        req_salida = 1'b0;
        fin_cerrada = 1'b1;
        ticks(5);
        chk("fault_sticky", 32'(outs()), 32'h1);
        do_reset();
        chk("fault_cleared", 32'(falla), 32'h0);

        // Both limit switches high.
        fin_abierta = 1'b1;
        tick();
        chk("both_limits", 32'(outs()), 32'h1);
        do_reset();

        // Obstacle while closing.
        req_entrada = 1'b1;
        tick();
        req_entrada = 1'b0;
        fin_cerrada = 1'b0;
        tick();
        fin_abierta = 1'b1;
        tick();
        entrada = 1'b1;
        tick();
        entrada = 1'b0;
        ticks(CIERRE);
        chk("obst_cerrando", 32'(motor_cerrar), 32'h1);
        fin_abierta = 1'b0;
        tick();
        obstaculo = 1'b1;
        tick();
        obstaculo = 1'b0;
`ifdef ANTIPINZA_EN
        chk("obst_reabre", 32'({motor_abrir, motor_cerrar}), 32'h2);
        fin_abierta = 1'b1;
        tick();
        chk("obst_misma_dir", 32'({verde_entrada, verde_salida}), 32'h2);
`else
        chk("obst_ignorado", 32'({motor_abrir, motor_cerrar}), 32'h1);
        fin_cerrada = 1'b1;
        tick();
        chk("obst_cierre_ok", 32'({motor_cerrar, falla}), 32'h0);
`endif
        do_reset();
        chk("final_idle", 32'(outs()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/control_barrera.md
Name: control_barrera

Overview:
- Controller for a single shared barrier lane in the parking-lot design. Entry and exit both use this one barrier.
- Latches debounced entry and exit requests and arbitrates between them.
- Blocks entry when the free-space count is 0.
- Sequences the barrier motor (open, hold, close) using limit switches and timers.
- Sits beside the detector and space counter: consumes their entrada/salida pulses and espacio; drives motor and lane lights.

Parameters:
- T_MOTOR_MAX, 16'd5000: max cycles allowed for the motor to reach a limit switch; exceeding it is a fault.
- T_PASO, 16'd50000: max cycles the barrier stays open waiting for the car to pass.
- T_CIERRE, 16'd2000: delay in cycles from the pass pulse until closing starts.
- TIMER_W, 16: timer width; every timer parameter must be < 2**TIMER_W.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_entrada  in  1  1-cycle pulse, debounced entry request
- req_salida  in  1  1-cycle pulse, debounced exit request
- espacio  in  7  free spaces from the space counter
- entrada  in  1  1-cycle pulse from detector: car completed entry
- salida  in  1  1-cycle pulse from detector: car completed exit
- fin_abierta  in  1  open limit switch, already synchronized
- fin_cerrada  in  1  closed limit switch, already synchronized
- obstaculo  in  1  level, object under barrier
- motor_abrir  out  1  drive motor open
- motor_cerrar  out  1  drive motor closed
- verde_entrada  out  1  entry lane green light
- verde_salida  out  1  exit lane green light
- lleno  out  1  entry request pending while espacio==0
- falla  out  1  motor/limit fault, sticky

Behaviour:
- All outputs registered and decoded from state plus the grant register. Reset value of every output is 0; state resets to REPOSO; pendientes clear; ultimo resets to SALIDA.
- Pending flags:
  - A req pulse sets pend_ent / pend_sal.
  - A flag clears the cycle its grant is taken.
  - A req for the direction currently being served re-sets the flag, so it is served next.
- Eligibility: entry is eligible iff pend_ent && espacio!=0; exit is eligible iff pend_sal.
- lleno = pend_ent && espacio==0, registered.
- Arbitration, evaluated only in REPOSO:
  - If both are eligible, grant the direction != ultimo.
  - ultimo updates at grant.
- REPOSO -> ABRIENDO the cycle after any eligible grant. Timer clears on every state entry.
- ABRIENDO:
  - motor_abrir=1.
  - fin_abierta -> ABIERTA.
  - timer==T_MOTOR_MAX-1 -> FALLA.
- ABIERTA:
  - Green light for the granted direction only.
  - Pass pulse for the granted direction -> ESPERA.
  - Pass pulse for the other direction is ignored.
  - timer==T_PASO-1 -> CERRANDO; no pass is recorded.
- ESPERA:
  - Green stays on.
  - timer==T_CIERRE-1 -> CERRANDO.
- CERRANDO:
  - motor_cerrar=1, lights off.
  - fin_cerrada -> REPOSO.
  - timer==T_MOTOR_MAX-1 -> FALLA.
- FALLA:
  - Motors off, lights off, falla=1.
  - Exit only via reset.
- Both limit switches high in any state -> FALLA next cycle.
- motor_abrir and motor_cerrar are never 1 in the same cycle.
- Reset asserted mid-motion: outputs 0 immediately (async); state restarts at REPOSO.

Optional Feature:
- Macro: ANTIPINZA_EN.
- Defined: in CERRANDO, obstaculo=1 -> ABRIENDO with the same grant; timer cleared; no new arbitration.
- Not defined: obstaculo is ignored and the port is left unused.

Decomposition:
- parking_pkg:
  - state enum REPOSO/ABRIENDO/ABIERTA/ESPERA/CERRANDO/FALLA
  - direction constants DIR_ENTRADA / DIR_SALIDA
  - 7-bit space width constant, shared with the space counter
- Sub-module temporizador: TIMER_W-bit up-counter with synchronous clear and terminal-compare output, instantiated once.

Test Plan (T_MOTOR_MAX=16, T_PASO=32, T_CIERRE=4):
- Entry with espacio=10:
  - Stimulus: req_entrada; fin_abierta at +5; entrada at +10.
  - Required: motor_abrir 1 cycle after req; verde_entrada after fin_abierta; motor_cerrar 4 cycles after entrada; REPOSO on fin_cerrada.
- Full lot, espacio=0:
  - Stimulus: req_entrada, then espacio->1 after 20 cycles.
  - Required: lleno=1 and motors idle while espacio=0; grant 1 cycle after espacio->1; lleno=0.
- Simultaneous req_entrada and req_salida after reset:
  - Required: entry served first, exit served next.
  - Repeat both: exit first, since ultimo=ENTRADA.
- No pass: barrier open, no entrada/salida.
  - Required: CERRANDO after 32 cycles; pend flags clear.
- Motor fault:
  - Stimulus: fin_abierta never asserts.
  - Required: falla=1 after 16 cycles; motors 0; stuck until reset.
  - Also: both limits high -> falla.
- ANTIPINZA_EN on:
  - Stimulus: obstaculo=1 during CERRANDO.
  - Required: motor_abrir next cycle, same green direction.
  - Macro off: close completes normally.
